// File: rtl/ahb_bridge_pkg.sv
// rtl/ahb_bridge_pkg.sv - shared codes, window geometry and FSM states for the AHB slave front end
package ahb_bridge_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [31:0] BRIDGE_BASE = 32'h8000_0000;
   localparam logic [32:0] REGION_SIZE = 33'h0_0400_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_RPUSH,
      ST_RWAIT,
      ST_ERR1,
      ST_ERR2
   } state_e;

   // 33-bit compare so the window top never wraps past 4 GB
   function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                      input int idx);
      logic [32:0] lo;
      lo = {1'b0, base} + REGION_SIZE * 33'(idx);
      return ({1'b0, addr} >= lo) && ({1'b0, addr} < lo + REGION_SIZE);
   endfunction

endpackage

// File: rtl/ahb_slave_if_if.sv
// rtl/ahb_slave_if_if.sv - AHB-Lite bus bundle between master and the bridge slave port
interface ahb_slave_if_if;

   logic        Hwrite;
   logic        Hready_in;
   logic [1:0]  Htrans;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic        Hready_out;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata;

   modport master (
      output Hwrite, Hready_in, Htrans, Haddr, Hwdata,
      input  Hready_out, Hresp, Hrdata
   );

   modport slave (
      input  Hwrite, Hready_in, Htrans, Haddr, Hwdata,
      output Hready_out, Hresp, Hrdata
   );

endinterface

// File: rtl/ahb_req_fifo.sv
// rtl/ahb_req_fifo.sv - request queue; a pop frees its slot for a push on the same edge
module ahb_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 68
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL_CNT);
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB-Lite slave front end: decode, write-data pipelining, read stall, ERROR
module ahb_slave_if
   import ahb_bridge_pkg::*;
#(
   parameter int          DEPTH = 4,
   parameter logic [31:0] BASE  = BRIDGE_BASE,
   parameter int          NSLV  = 3
) (
   input  logic             Hclk,
   input  logic             Hresetn,
   ahb_slave_if_if.slave    ahb,
   output logic             req_valid,
   output logic             req_write,
   output logic [31:0]      req_addr,
   output logic [31:0]      req_wdata,
   output logic [NSLV-1:0]  req_sel,
   input  logic             req_ready,
   input  logic             rsp_valid,
   input  logic [31:0]      rsp_rdata
);

   localparam int EW = 32 + 1 + 32 + NSLV;
   localparam int CW = $clog2(DEPTH) + 1;

   state_e          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [NSLV-1:0] sel_q, sel_d, sel_dec;
   logic [31:0]     hrdata_q, hrdata_d;
   logic            push, pop, can_push, full, empty, accept, addr_phase, hready;
   logic [1:0]      hresp;
   logic [EW-1:0]   push_data, head;
   logic [CW-1:0]   count;

   always_comb begin
      sel_dec = '0;
      for (int i = 0; i < NSLV; i++) sel_dec[i] = in_region(ahb.Haddr, BASE, i);
   end

   assign accept   = ahb.Hready_in && (ahb.Htrans == HTRANS_NONSEQ || ahb.Htrans == HTRANS_SEQ);
   assign pop      = !empty && req_ready;
   assign can_push = !full || pop;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      hrdata_d   = hrdata_q;
      push       = 1'b0;
      push_data  = {addr_q, 1'b1, ahb.Hwdata, sel_q};
      hready     = 1'b1;
      hresp      = HRESP_OKAY;
      addr_phase = 1'b0;
      case (state_q)
         ST_IDLE:  addr_phase = 1'b1;
         ST_WDATA: begin
            hready     = can_push;
            push       = can_push;
            addr_phase = can_push;
         end
         ST_RPUSH: begin
            hready    = 1'b0;
            push      = can_push;
            push_data = {addr_q, 1'b0, 32'h0, sel_q};
            if (can_push) state_d = ST_RWAIT;
         end
         ST_RWAIT: begin
            hready = 1'b0;
            if (rsp_valid) begin
               hrdata_d = rsp_rdata;
               state_d  = ST_IDLE;
            end
         end
         ST_ERR1: begin
            hready  = 1'b0;
            hresp   = HRESP_ERROR;
            state_d = ST_ERR2;
         end
         ST_ERR2: begin
            hresp      = HRESP_ERROR;
            addr_phase = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      // Any cycle that completes a data phase also samples the next address phase
      if (addr_phase) begin
         state_d = ST_IDLE;
         if (accept) begin
            addr_d = ahb.Haddr;
            sel_d  = sel_dec;
            if (sel_dec == '0) state_d = ST_ERR1;
            else if (ahb.Hwrite) state_d = ST_WDATA;
            else state_d = ST_RPUSH;
         end
      end
   end

   always_ff @(posedge Hclk) begin
      if (Hresetn) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         sel_q    <= '0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         sel_q    <= sel_d;
         hrdata_q <= hrdata_d;
      end
   end

   ahb_req_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
      .clk_i   (Hclk),
      .rst_i   (Hresetn),
      .push_i  (push),
      .din_i   (push_data),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   count_in_range: assert property (@(posedge Hclk) disable iff (Hresetn) count <= CW'(DEPTH));

   assign ahb.Hready_out = hready;
   assign ahb.Hresp      = hresp;
   assign ahb.Hrdata     = hrdata_q;
   assign req_valid      = !empty;
   assign {req_addr, req_write, req_wdata, req_sel} = head;

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - directed bench with request scoreboard for ahb_slave_if
module tb_ahb_slave_if;
   import ahb_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        hin_block;
   logic        req_valid, req_write, req_ready, rsp_valid;
   logic [31:0] req_addr, req_wdata, rsp_rdata, rsp_data;
   logic [2:0]  req_sel;
   logic [67:0] exp_q [$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          rsp_due = -1;
   int          rsp_delay = 1;
   int          ws;

   ahb_slave_if_if bus ();

   assign bus.Hready_in = hin_block ? 1'b0 : bus.Hready_out;

   always #5 clk = ~clk;

   ahb_slave_if #(.DEPTH(4), .BASE(32'h8000_0000), .NSLV(3)) dut (
      .Hclk      (clk),
      .Hresetn   (rst),
      .ahb       (bus),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_sel   (req_sel),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // APB-side responder: answers a popped read rsp_delay cycles after the pop edge
   always @(posedge clk) begin
      cyc++;
      #1;
      rsp_valid = (cyc == rsp_due);
      rsp_rdata = rsp_valid ? rsp_data : 32'h0;
   end

   always @(negedge clk) begin
      if (!rst && req_valid === 1'b1 && req_ready) begin
         check("pop_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0)
            check("req_entry", {req_addr, req_write, req_wdata, req_sel}, exp_q.pop_front());
         if (!req_write) rsp_due = cyc + rsp_delay;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         bus.Htrans = HTRANS_IDLE;
      end
   endtask

   task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [1:0] tr);
      tick();
      bus.Htrans = tr;
      bus.Hwrite = wr;
      bus.Haddr  = a;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      @(negedge clk);
      while (!bus.Hready_out && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sel);
      int n;
      exp_q.push_back({a, 1'b1, d, sel});
      addr_phase(1'b1, a, HTRANS_NONSEQ);
      tick();
      bus.Htrans = HTRANS_IDLE;
      bus.Hwdata = d;
      wait_ready(n);
      check("write_wait_states", n, 0);
      check("write_hresp", bus.Hresp, HRESP_OKAY);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [2:0] sel, input logic [31:0] d,
                          input int delay, input int exp_ws);
      int n;
      rsp_delay = delay;
      rsp_data  = d;
      exp_q.push_back({a, 1'b0, 32'h0, sel});
      addr_phase(1'b0, a, HTRANS_NONSEQ);
      tick();
      bus.Htrans = HTRANS_IDLE;
      wait_ready(n);
      check("read_wait_states", n, exp_ws);
      check("read_hrdata", bus.Hrdata, d);
      check("read_hresp", bus.Hresp, HRESP_OKAY);
   endtask

   task automatic do_error(input logic [31:0] a);
      addr_phase(1'b1, a, HTRANS_NONSEQ);
      tick();
      bus.Htrans = HTRANS_IDLE;
      bus.Hwdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check("err1_hresp", bus.Hresp, HRESP_ERROR);
      check("err1_hready", bus.Hready_out, 1'b0);
      @(negedge clk);
      check("err2_hresp", bus.Hresp, HRESP_ERROR);
      check("err2_hready", bus.Hready_out, 1'b1);
      @(negedge clk);
      check("err_after_hresp", bus.Hresp, HRESP_OKAY);
      check("err_no_push", req_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b1;
      hin_block  = 1'b0;
      req_ready  = 1'b0;
      rsp_data   = 32'h0;
      bus.Htrans = HTRANS_IDLE;
      bus.Hwrite = 1'b0;
      bus.Haddr  = 32'h0;
      bus.Hwdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_hready", bus.Hready_out, 1'b1);
      check("reset_hresp", bus.Hresp, HRESP_OKAY);
      check("reset_hrdata", bus.Hrdata, 32'h0);
      check("reset_req_valid", req_valid, 1'b0);
      tick();
      rst       = 1'b0;
      req_ready = 1'b1;

      do_write(32'h8000_0001, 32'h8000_5441, 3'b001);
      drain();
      do_read(32'h8400_0010, 3'b010, 32'hDEAD_BEEF, 2, 4);
      idle(2);
      do_read(32'h8800_0100, 3'b100, 32'h1234_5678, 1, 3);
      idle(2);

      // Five pipelined writes into a 4-deep queue with the consumer stalled
      req_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         exp_q.push_back({32'h8000_0100 + 32'(4 * i), 1'b1, 32'hA000_0000 + 32'(i), 3'b001});
      addr_phase(1'b1, 32'h8000_0100, HTRANS_NONSEQ);
      for (int i = 1; i < 5; i++) begin
         tick();
         bus.Hwdata = 32'hA000_0000 + 32'(i - 1);
         bus.Haddr  = 32'h8000_0100 + 32'(4 * i);
         bus.Htrans = HTRANS_SEQ;
         @(negedge clk);
         check("b2b_ready", bus.Hready_out, 1'b1);
      end
      tick();
      bus.Hwdata = 32'hA000_0004;
      bus.Htrans = HTRANS_IDLE;
      @(negedge clk);
      check("b2b_full_stall", bus.Hready_out, 1'b0);
      check("b2b_head_valid", req_valid, 1'b1);
      tick();
      @(negedge clk);
      check("b2b_still_stalled", bus.Hready_out, 1'b0);
      tick();
      req_ready = 1'b1;
      @(negedge clk);
      check("b2b_released", bus.Hready_out, 1'b1);
      drain();

      req_ready = 1'b0;
      do_error(32'h9000_0000);
      do_error(32'h8C00_0000);
      do_error(32'h7FFF_FFFC);
      req_ready = 1'b1;
      do_write(32'h8BFF_FFFC, 32'h0BAD_CAFE, 3'b100);
      do_write(32'h8000_0000, 32'h0000_0001, 3'b001);
      drain();

      req_ready = 1'b0;
      addr_phase(1'b1, 32'h8000_0040, HTRANS_IDLE);
      @(negedge clk);
      check("idle_hready", bus.Hready_out, 1'b1);
      addr_phase(1'b1, 32'h8000_0040, HTRANS_BUSY);
      @(negedge clk);
      check("busy_hresp", bus.Hresp, HRESP_OKAY);
      idle(2);
      @(negedge clk);
      check("idle_busy_no_push", req_valid, 1'b0);
      check("idle_busy_hready", bus.Hready_out, 1'b1);

      hin_block = 1'b1;
      addr_phase(1'b1, 32'h8000_0080, HTRANS_NONSEQ);
      tick();
      bus.Htrans = HTRANS_IDLE;
      hin_block  = 1'b0;
      tick();
      @(negedge clk);
      check("hready_in_low_no_push", req_valid, 1'b0);
      check("hready_in_low_hready", bus.Hready_out, 1'b1);

      // Reset while a read waits behind two queued writes
      do_write(32'h8000_0200, 32'h0000_0011, 3'b001);
      do_write(32'h8400_0204, 32'h0000_0022, 3'b010);
      exp_q.push_back({32'h8800_0300, 1'b0, 32'h0, 3'b100});
      addr_phase(1'b0, 32'h8800_0300, HTRANS_NONSEQ);
      tick();
      bus.Htrans = HTRANS_IDLE;
      @(negedge clk);
      check("rpush_hready", bus.Hready_out, 1'b0);
      tick();
      @(negedge clk);
      check("rwait_hready", bus.Hready_out, 1'b0);
      check("rwait_queue_valid", req_valid, 1'b1);
      tick();
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("midreset_hready", bus.Hready_out, 1'b1);
      check("midreset_hresp", bus.Hresp, HRESP_OKAY);
      check("midreset_hrdata", bus.Hrdata, 32'h0);
      check("midreset_req_valid", req_valid, 1'b0);

      req_ready = 1'b1;
      do_write(32'h8000_0300, 32'h0000_0033, 3'b001);
      drain();
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
